// File: rtl/hvrx_pkg.sv
// hvrx_pkg: shared TMDS receive constants, lock FSM states and control-token lookup
package hvrx_pkg;

   localparam logic [9:0] TOK_CTL0 = 10'b1101010100;
   localparam logic [9:0] TOK_CTL1 = 10'b0010101011;
   localparam logic [9:0] TOK_CTL2 = 10'b0101010100;
   localparam logic [9:0] TOK_CTL3 = 10'b1010101011;

   typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} hvrx_state_e;

   typedef struct packed {
      logic       is_ctl;
      logic [1:0] ctl;
   } ctl_dec_t;

   function automatic ctl_dec_t ctl_of_token(input logic [9:0] sym);
      ctl_dec_t r;
      r.is_ctl = (sym == TOK_CTL0) || (sym == TOK_CTL1) || (sym == TOK_CTL2) || (sym == TOK_CTL3);
      r.ctl    = (sym == TOK_CTL0) ? 2'd0 : (sym == TOK_CTL1) ? 2'd1 : (sym == TOK_CTL2) ? 2'd2 : 2'd3;
      return r;
   endfunction

endpackage

// File: rtl/hvrx_tmds_dec.sv
// hvrx_tmds_dec: combinational 10b-to-8b data decode plus control-token classification
module hvrx_tmds_dec
   import hvrx_pkg::*;
(
   input  logic [9:0] sym,
   output logic [7:0] data,
   output logic       is_ctl,
   output logic [1:0] ctl
);

   logic [7:0] q;
   ctl_dec_t   cd;

   // bit 9 marks an inverted payload, bit 8 selects xor (1) or xnor (0) chaining
   assign q      = sym[9] ? ~sym[7:0] : sym[7:0];
   assign data   = {q[7:1] ^ q[6:0] ^ {7{~sym[8]}}, q[0]};
   assign cd     = ctl_of_token(sym);
   assign is_ctl = cd.is_ctl;
   assign ctl    = cd.ctl;

endmodule

// File: rtl/hvrx_tmds_chan.sv
// hvrx_tmds_chan: per-channel TMDS symbol alignment by bit-slip, decode and lock reporting
module hvrx_tmds_chan
   import hvrx_pkg::*;
#(
   parameter int CTL_RUN = 16,
   parameter int TIMEOUT = 4096
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [9:0] i_word,
   output logic [7:0] o_data,
   output logic [1:0] o_ctl,
   output logic       o_de,
   output logic       o_locked,
   output logic [3:0] o_slip
);

   localparam int RW = $clog2(CTL_RUN + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [9:0]  w0, w1, sym;
   logic [19:0] c;
   logic [4:0]  base;
   logic [3:0]  s;
   logic        hold;
   logic [RW-1:0] run_cnt, run_nxt;
   logic [TW-1:0] timer;
   hvrx_state_e state, state_nxt;
   logic        run_done, tmo, slip;
   logic [7:0]  dec_data, data_nxt;
   logic [1:0]  dec_ctl, ctl_nxt;
   logic        dec_is_ctl, de_nxt;

   // slip s takes s bits from the older word, so the window starts 10-s bits into c
   assign c    = {w0, w1};
   assign base = 5'd10 - {1'b0, s};

   hvrx_tmds_dec u_dec (
      .sym    (sym),
      .data   (dec_data),
      .is_ctl (dec_is_ctl),
      .ctl    (dec_ctl)
   );

   // the sym right after a slip was still cut at the old position, so it never counts
   assign run_nxt  = (hold || !dec_is_ctl) ? '0 : (run_cnt == RW'(CTL_RUN)) ? run_cnt : run_cnt + 1'b1;
   assign run_done = (run_nxt == RW'(CTL_RUN));
   assign tmo      = (timer == TW'(TIMEOUT - 1));
   assign o_locked = (state == LOCKED);
   assign o_slip   = s;

   // lock state register
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) state <= SEARCH;
      else          state <= state_nxt;

   // a completed run always wins over a coincident timeout; a timeout in either state slips
   always_comb begin
      state_nxt = run_done ? LOCKED : tmo ? SEARCH : state;
      slip      = !run_done && tmo;
   end

   // word history, symbol window, run and gap counters, slip position
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         w0      <= '0;
         w1      <= '0;
         sym     <= '0;
         timer   <= '0;
         run_cnt <= '0;
         hold    <= 1'b0;
         s       <= '0;
      end else begin
         w0      <= i_word;
         w1      <= w0;
         sym     <= c[base +: 10];
         timer   <= (run_done || slip) ? '0 : timer + 1'b1;
         run_cnt <= slip ? '0 : run_nxt;
         hold    <= slip;
         s       <= !slip ? s : (s == 4'd9) ? 4'd0 : s + 4'd1;
      end

   // outputs are gated by the lock state that takes effect at the same edge
   always_comb begin
      de_nxt   = (state_nxt == LOCKED) && !dec_is_ctl;
      data_nxt = de_nxt ? dec_data : '0;
      ctl_nxt  = (state_nxt != LOCKED) ? 2'b00 : dec_is_ctl ? dec_ctl : o_ctl;
   end

   // decoded output register
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         o_data <= '0;
         o_ctl  <= '0;
         o_de   <= 1'b0;
      end else begin
         o_data <= data_nxt;
         o_ctl  <= ctl_nxt;
         o_de   <= de_nxt;
      end

endmodule

// File: doc/hvrx_tmds_chan.md
# hvrx_tmds_chan

Receive-side counterpart of the TMDS transmit chain: one instance per TMDS channel, fed by a 1:10 deserializer running on the pixel clock. It finds the 10-bit symbol boundary by bit-slipping until a run of control tokens is seen. It then decodes data symbols back to 8-bit video and control tokens back to the 2-bit control value, and reports lock. Three instances plus a sync regenerator form the receiver.

## Interface

Parameters:
- CTL_RUN, 16: consecutive control tokens required to declare alignment.
- TIMEOUT, 4096: cycles allowed per slip position in SEARCH, and the maximum gap between control runs in LOCKED.

Ports:
- i_clk, input, 1: pixel clock, the only clock.
- i_rst_n, input, 1: asynchronous, active-low reset.
- i_word, input, 10: deserialized word, one per clock; i_word[0] is the first serial bit.
- o_data, output, 8: decoded video byte.
- o_ctl, output, 2: last decoded control value ({vs, hs} on channel 0).
- o_de, output, 1: current symbol is a data symbol.
- o_locked, output, 1: alignment acquired.
- o_slip, output, 4: current slip position, 0..9, for debug.

## Operation

- Word history: w0 <= i_word, w1 <= w0; c = {w0, w1} (20 bits).
- Slip s (0..9) selects the aligned symbol sym <= c[(10-s)+:10]. For s=0 this is w0; s is the number of bits taken from the previous word.
- Control tokens, bit 9 leftmost:
  - 1101010100 decodes to ctl 00
  - 0010101011 decodes to ctl 01
  - 0101010100 decodes to ctl 10
  - 1010101011 decodes to ctl 11
- Any other value is a data symbol.
- Data decode: q = sym[9] ? ~sym[7:0] : sym[7:0]; d[0] = q[0]; for i = 1..7, d[i] = sym[8] ? q[i]^q[i-1] : ~(q[i]^q[i-1]).
- run_cnt counts consecutive control-token syms, saturating at CTL_RUN; it clears on any data sym.
- timer counts up by one per clock. Width of run_cnt and timer is $clog2(param+1).
- FSM, two states:
  - SEARCH, reset state: if run_cnt reaches CTL_RUN, go to LOCKED and clear timer. Otherwise, when timer == TIMEOUT-1, set s = (s+1) mod 10 and clear timer and run_cnt.
  - LOCKED: clear timer every cycle in which run_cnt == CTL_RUN. Otherwise, when timer == TIMEOUT-1, go to SEARCH, advance s, and clear run_cnt.
- Same-cycle run completion and timeout: completion wins; no slip occurs.
- After any slip, the next sym still comes from the old slip, so run_cnt is held at 0 for 1 cycle.
- Output register:
  - o_locked = (state == LOCKED).
  - While not locked: o_de = 0, o_data = 0, o_ctl = 00.
  - While locked, on a data sym: o_de = 1, o_data = d, o_ctl holds its value.
  - While locked, on a control sym: o_de = 0, o_ctl = decoded value, o_data = 0.

## Timing

- Reset values: o_data = 0, o_ctl = 00, o_de = 0, o_locked = 0, o_slip = 0; s = 0, state = SEARCH, counters = 0, w0 = w1 = sym = 0.
- Reset is asynchronous assert; deassertion is taken synchronously by the flops. Reset mid-operation drops lock immediately.
- Latency: the word holding a symbol's last bit is sampled at edge e, and o_data/o_de/o_ctl for that symbol are valid after edge e+2. Latency is the same for every s.
- o_locked rises in the same output cycle as the CTL_RUN-th control token's outputs.
- o_slip changes the cycle after the timeout edge.
- Worst-case acquisition: 10 × TIMEOUT cycles plus one blanking run.

## Structure

- Shared package hvrx_pkg: the four control-token constants, a state enum {SEARCH, LOCKED}, and the ctl-from-token function.
- Sub-module hvrx_tmds_dec: combinational 10b-to-8b data decode plus control-token classification (is_ctl, ctl[1:0]). It is reusable by a future TERC4 path.

## Test plan

- Aligned stream (s=0): 20 × token 1101010100, then TMDS-encoded bytes 0x00, 0xFF, 0x5A, 0xA5.
  - o_locked rises after the 16th token plus 2 cycles; o_ctl = 00.
  - Bytes appear on o_data 2 cycles after input with o_de = 1.
- Stream rotated by 7 bits with repeating blanking (300 tokens, 1350 data symbols):
  - o_slip steps 0, 1, … at TIMEOUT intervals and stops at 7.
  - o_locked = 1; decoded bytes match the source.
- Control decode: while locked, tokens 0010101011, 0101010100, 1010101011 → o_ctl = 01, 10, 11; o_ctl holds 11 through a following data burst.
- Loss of lock: after lock, feed data symbols only for 4096 cycles.
  - o_locked falls, o_de = 0, o_slip advances by one.
- Boundary: the 16th control token arrives on the exact timeout cycle → lock is taken and o_slip is unchanged.
  - A 15-token run followed by one data symbol never locks.
- Reset: pull i_rst_n low mid-frame while locked → all outputs read 0 asynchronously; reacquisition completes after reset is released.
